service_bay_arbiter: RTL and testbench
======================================

Name: service_bay_arbiter

Overview:
Shares the single service bay between the car-wash lane and the workshop ("taller") lane. Each lane has a request button and a 4-bit one-hot program selector. The block counts waiting cars per lane and grants the bay round-robin. For each granted car it latches the program and runs a service timer whose length depends on that program. It sits between the selector/push-button inputs and the lane FSMs, which consume the grant, program and done outputs.

Parameters:
QW, 3, width of per-lane waiting counters; max queue depth = 2^QW-1 (default 7)
BASE_T, 4, service cycles per program step; duration = BASE_T*(k+1)
TW, 5, timer width; must hold 4*BASE_T-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req_wash  input  1  car-wash request button, level, may be held multiple cycles
req_shop  input  1  workshop request button, level
wash_sel  input  4  car-wash program select, one-hot
shop_sel  input  4  workshop program select, one-hot
abort  input  1  cancel current service
grant_wash  output  1  bay serving car-wash lane
grant_shop  output  1  bay serving workshop lane
prog  output  3  active program code, 0 = none, k+1 for selector bit k
busy  output  1  FSM not IDLE
done  output  1  one-cycle pulse, service completed
reject_wash  output  1  one-cycle pulse, wash request dropped because queue full
reject_shop  output  1  one-cycle pulse, shop request dropped because queue full
q_wash  output  QW  cars waiting, wash lane
q_shop  output  QW  cars waiting, shop lane

Behaviour:
- Reset (synchronous, active-high; state is checked at the clock edge): state=IDLE; all outputs 0; timer=0; edge registers=0; last_served=SHOP, so the wash lane wins the first tie.
- Edge detect: registered copy of each req input. pulse = req & ~req_q. A held button counts once.
- Queue counters:
  - A pulse increments the lane counter.
  - If the counter equals 2^QW-1, the count is unchanged and reject_x is driven 1 for that cycle.
  - A grant decrements the counter.
  - Pulse and grant on the same lane in the same cycle: count unchanged, no reject.
- Program decode:
  - k = index of the lowest set bit of the lane's selector.
  - Selector 0000 gives k=0.
  - Multiple bits set: the lowest set bit wins.
  - Code = k+1.
- IDLE:
  - If exactly one queue is nonzero, that lane wins.
  - If both are nonzero, the lane != last_served wins.
  - On a win: latch lane; latch prog from that lane's selector sampled this cycle; timer <= BASE_T*(k+1)-1; decrement that queue; next state SERVE.
  - If both queues are 0, stay in IDLE.
- SERVE:
  - grant_<lane>=1 and busy=1; prog holds the latched code.
  - Selector changes are ignored while serving.
  - If timer==0, go to DONE; otherwise timer decrements.
  - Occupancy is exactly BASE_T*(k+1) cycles.
- DONE:
  - done=1 for one cycle; grants=0; prog holds.
  - last_served <= latched lane; next state IDLE.
  - prog returns to 0 in IDLE.
- abort:
  - Sampled in SERVE only; it has priority over timer expiry.
  - Next state IDLE; grants=0; prog=0; no done pulse; last_served is updated; the aborted car is not requeued.
  - abort in IDLE or DONE is ignored.
- Requests keep queueing during SERVE and DONE.
- Minimum gap between consecutive services: DONE cycle + IDLE decision cycle = 2 cycles with no grant.
- Reset mid-SERVE: at the reset edge the state becomes IDLE, queues clear, the grant drops and done stays 0.

Test Plan:
- Single wash, default parameters:
  - Stimulus: after reset, wash_sel=1000; hold req_wash 3 cycles starting at cycle n.
  - Response: q_wash=1 at n+1; grant_wash=1 and prog=100 from n+2 for 16 cycles; q_wash=0; done pulses at n+18; state IDLE at n+19; no further grant.
- Round-robin:
  - Stimulus: req_wash and req_shop pulse in the same cycle; wash_sel=0001, shop_sel=0010.
  - Response: wash served first for 4 cycles with prog=001; 2 idle cycles; shop served for 8 cycles with prog=010.
  - Then two more of each, queued while the bay is busy, alternate W,S,W,S.
- Queue full:
  - Stimulus: 8 distinct wash pulses while the shop lane is being served.
  - Response: q_wash saturates at 7; reject_wash pulses exactly once, on the 8th pulse.
  - Then a decrement and a new pulse in the same cycle keep q_wash at 6 with no reject.
- Selector decode:
  - Stimulus: wash_sel=0000 gives prog=001 and 4 cycles; wash_sel=0110 gives prog=010 and 8 cycles.
  - Stimulus: changing wash_sel mid-SERVE.
  - Response: prog and duration are unchanged by the mid-SERVE change.
- Abort:
  - Stimulus: abort at the 3rd SERVE cycle of a 16-cycle shop service, with one wash car queued.
  - Response: grant_shop drops the next cycle; done stays 0; the wash car is granted after the IDLE decision cycle.
  - abort held in IDLE has no effect.
- Reset mid-operation:
  - Stimulus: assert reset during SERVE with q_shop=3.
  - Response: at the next edge all outputs are 0 and queues are 0; a fresh wash/shop tie then grants wash first.

Source files
------------

// File: rtl/service_bay_arbiter.sv
// Service bay arbiter: queues car-wash and workshop requests and grants the
// single bay round-robin, running a program-dependent service timer per car.
module service_bay_arbiter #(
   parameter int unsigned QW     = 3,
   parameter int unsigned BASE_T = 4,
   parameter int unsigned TW     = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_wash,
   input  logic          req_shop,
   input  logic [3:0]    wash_sel,
   input  logic [3:0]    shop_sel,
   input  logic          abort,
   output logic          grant_wash,
   output logic          grant_shop,
   output logic [2:0]    prog,
   output logic          busy,
   output logic          done,
   output logic          reject_wash,
   output logic          reject_shop,
   output logic [QW-1:0] q_wash,
   output logic [QW-1:0] q_shop
);

   typedef enum logic [1:0] {StIdle, StServe, StDone} state_t;

   // Lane encoding: 0 = wash, 1 = shop.
   localparam logic LaneWash = 1'b0;
   localparam logic LaneShop = 1'b1;

   localparam logic [QW-1:0] QMax = {QW{1'b1}};
   localparam logic [QW-1:0] QOne = QW'(1);
   localparam logic [TW-1:0] TOne = TW'(1);

   state_t        state_q, state_d;
   logic          lane_q, lane_d;
   logic          last_q, last_d;
   logic [2:0]    prog_q, prog_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          req_wash_q, req_shop_q;
   logic [QW-1:0] q_wash_q, q_wash_d;
   logic [QW-1:0] q_shop_q, q_shop_d;

   logic          pulse_wash, pulse_shop;
   logic          win, win_lane;
   logic          dec_wash, dec_shop;
   logic [1:0]    k_wash, k_shop, k_win;

   // Lowest set selector bit; an empty selector falls back to program 0.
   function automatic logic [1:0] low_bit(input logic [3:0] sel);
      if (sel[0])      return 2'd0;
      else if (sel[1]) return 2'd1;
      else if (sel[2]) return 2'd2;
      else if (sel[3]) return 2'd3;
      else             return 2'd0;
   endfunction

   assign pulse_wash = req_wash & ~req_wash_q;
   assign pulse_shop = req_shop & ~req_shop_q;
   assign k_wash     = low_bit(wash_sel);
   assign k_shop     = low_bit(shop_sel);

   // Bay FSM: pick a lane in IDLE, count down the service, pulse done.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      last_d   = last_q;
      prog_d   = prog_q;
      timer_d  = timer_q;
      win      = 1'b0;
      win_lane = LaneWash;
      k_win    = 2'd0;
      unique case (state_q)
         StIdle: begin
            if (q_wash_q != '0 || q_shop_q != '0) begin
               win = 1'b1;
               if (q_wash_q != '0 && q_shop_q != '0) begin
                  win_lane = ~last_q;
               end else begin
                  win_lane = (q_wash_q == '0) ? LaneShop : LaneWash;
               end
               k_win   = (win_lane == LaneShop) ? k_shop : k_wash;
               lane_d  = win_lane;
               prog_d  = {1'b0, k_win} + 3'd1;
               timer_d = TW'(BASE_T * (32'(k_win) + 32'd1) - 32'd1);
               state_d = StServe;
            end
         end
         StServe: begin
            // Abort wins over a timer expiring in the same cycle.
            if (abort) begin
               last_d  = lane_q;
               state_d = StIdle;
            end else if (timer_q == '0) begin
               state_d = StDone;
            end else begin
               timer_d = timer_q - TOne;
            end
         end
         StDone: begin
            last_d  = lane_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign dec_wash = win & (win_lane == LaneWash);
   assign dec_shop = win & (win_lane == LaneShop);

   // Waiting-car counters; a pulse on a full lane is dropped and flagged.
   always_comb begin
      q_wash_d    = q_wash_q;
      q_shop_d    = q_shop_q;
      reject_wash = 1'b0;
      reject_shop = 1'b0;
      if (pulse_wash && !dec_wash) begin
         if (q_wash_q == QMax) reject_wash = 1'b1;
         else                  q_wash_d    = q_wash_q + QOne;
      end else if (dec_wash && !pulse_wash) begin
         q_wash_d = q_wash_q - QOne;
      end
      if (pulse_shop && !dec_shop) begin
         if (q_shop_q == QMax) reject_shop = 1'b1;
         else                  q_shop_d    = q_shop_q + QOne;
      end else if (dec_shop && !pulse_shop) begin
         q_shop_d = q_shop_q - QOne;
      end
   end

   // State, counters and request edge registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         lane_q     <= LaneWash;
         last_q     <= LaneShop;
         prog_q     <= 3'd0;
         timer_q    <= '0;
         req_wash_q <= 1'b0;
         req_shop_q <= 1'b0;
         q_wash_q   <= '0;
         q_shop_q   <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         last_q     <= last_d;
         prog_q     <= prog_d;
         timer_q    <= timer_d;
         req_wash_q <= req_wash;
         req_shop_q <= req_shop;
         q_wash_q   <= q_wash_d;
         q_shop_q   <= q_shop_d;
      end
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      grant_wash = (state_q == StServe) && (lane_q == LaneWash);
      grant_shop = (state_q == StServe) && (lane_q == LaneShop);
      busy       = (state_q != StIdle);
      done       = (state_q == StDone);
      prog       = (state_q != StIdle) ? prog_q : 3'd0;
      q_wash     = q_wash_q;
      q_shop     = q_shop_q;
   end

endmodule

// File: tb/tb_service_bay_arbiter.sv
// Self-checking bench for service_bay_arbiter: directed scenarios with pinned
// literal expectations, then random traffic, all checked against a lane/queue
// model every cycle.
module tb_service_bay_arbiter;

   localparam int QW     = 3;
   localparam int BASE_T = 4;
   localparam int TW     = 5;
   localparam int QMAX   = (1 << QW) - 1;

   logic          clk;
   logic          reset;
   logic          req_wash, req_shop;
   logic [3:0]    wash_sel, shop_sel;
   logic          abort;
   logic          grant_wash, grant_shop;
   logic [2:0]    prog;
   logic          busy, done;
   logic          reject_wash, reject_shop;
   logic [QW-1:0] q_wash, q_shop;

   int n_vec = 0;
   int n_err = 0;

   service_bay_arbiter #(
      .QW    (QW),
      .BASE_T(BASE_T),
      .TW    (TW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_wash   (req_wash),
      .req_shop   (req_shop),
      .wash_sel   (wash_sel),
      .shop_sel   (shop_sel),
      .abort      (abort),
      .grant_wash (grant_wash),
      .grant_shop (grant_shop),
      .prog       (prog),
      .busy       (busy),
      .done       (done),
      .reject_wash(reject_wash),
      .reject_shop(reject_shop),
      .q_wash     (q_wash),
      .q_shop     (q_shop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      cmp(nm, act, exp);
   endtask

   function automatic int lowest(input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) return b;
      return 0;
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 serving, 2 done. left = serve cycles still to run.
   int m_q[2];
   int m_prev[2];
   int m_phase, m_lane, m_last, m_prog, m_left;
   bit m_on = 0;
   int r_v[2], p_v[2], d_v[2];
   int wl, nq, kk;
   bit mwin;

   always @(negedge clk) begin
      r_v[0] = int'(req_wash);
      r_v[1] = int'(req_shop);
      for (int i = 0; i < 2; i++) p_v[i] = (r_v[i] == 1 && m_prev[i] == 0) ? 1 : 0;
      mwin = (m_phase == 0) && (m_q[0] > 0 || m_q[1] > 0);
      if (m_q[0] > 0 && m_q[1] > 0) wl = 1 - m_last;
      else                          wl = (m_q[0] > 0) ? 0 : 1;
      for (int i = 0; i < 2; i++) d_v[i] = (mwin && wl == i) ? 1 : 0;

      if (m_on) begin
         n_vec++;
         cmp("grant_wash", 32'(grant_wash), 32'(m_phase == 1 && m_lane == 0));
         cmp("grant_shop", 32'(grant_shop), 32'(m_phase == 1 && m_lane == 1));
         cmp("prog", 32'(prog), (m_phase != 0) ? m_prog : 0);
         cmp("busy", 32'(busy), 32'(m_phase != 0));
         cmp("done", 32'(done), 32'(m_phase == 2));
         cmp("reject_wash", 32'(reject_wash), 32'(p_v[0] == 1 && m_q[0] == QMAX && d_v[0] == 0));
         cmp("reject_shop", 32'(reject_shop), 32'(p_v[1] == 1 && m_q[1] == QMAX && d_v[1] == 0));
         cmp("q_wash", 32'(q_wash), m_q[0]);
         cmp("q_shop", 32'(q_shop), m_q[1]);
      end

      if (reset === 1'b1) begin
         m_on = 1;
         for (int i = 0; i < 2; i++) begin
            m_q[i]    = 0;
            m_prev[i] = 0;
         end
         m_phase = 0; m_lane = 0; m_last = 1; m_prog = 0; m_left = 0;
      end else if (m_on) begin
         for (int i = 0; i < 2; i++) begin
            nq = m_q[i] + p_v[i] - d_v[i];
            m_q[i]    = (nq > QMAX) ? QMAX : nq;
            m_prev[i] = r_v[i];
         end
         case (m_phase)
            0: if (mwin) begin
               kk      = lowest(wl == 1 ? shop_sel : wash_sel);
               m_phase = 1;
               m_lane  = wl;
               m_prog  = kk + 1;
               m_left  = BASE_T * (kk + 1);
            end
            1: if (abort === 1'b1) begin
               m_phase = 0;
               m_last  = m_lane;
            end else begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            default: begin
               m_phase = 0;
               m_last  = m_lane;
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req_wash = 1'b0; req_shop = 1'b0; abort = 1'b0;
      step();
      @(negedge clk);
      pin("rst grant_wash", 32'(grant_wash), 0);
      pin("rst grant_shop", 32'(grant_shop), 0);
      pin("rst prog", 32'(prog), 0);
      pin("rst busy", 32'(busy), 0);
      pin("rst done", 32'(done), 0);
      pin("rst q_wash", 32'(q_wash), 0);
      pin("rst q_shop", 32'(q_shop), 0);
      step();
      reset = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done === 1'b1) return;
         step();
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_done: no done pulse within %0d cycles", limit);
   endtask

   initial begin
      reset = 1'b1; req_wash = 1'b0; req_shop = 1'b0; abort = 1'b0;
      wash_sel = 4'b0000; shop_sel = 4'b0000;

      // Single wash, program bit 3 -> 16 cycles.
      do_reset();
      wash_sel = 4'b1000; req_wash = 1'b1;                  // cycle n
      step(); @(negedge clk);                                // n+1
      pin("single q_wash n+1", 32'(q_wash), 1);
      step(); @(negedge clk);                                // n+2
      pin("single grant n+2", 32'(grant_wash), 1);
      pin("single prog n+2", 32'(prog), 4);
      pin("single q_wash n+2", 32'(q_wash), 0);
      step(); req_wash = 1'b0;                               // n+3
      repeat (14) step();                                    // n+17
      @(negedge clk);
      pin("single grant n+17", 32'(grant_wash), 1);
      step(); @(negedge clk);                                // n+18
      pin("single done n+18", 32'(done), 1);
      pin("single grant n+18", 32'(grant_wash), 0);
      step(); @(negedge clk);                                // n+19
      pin("single busy n+19", 32'(busy), 0);
      pin("single prog n+19", 32'(prog), 0);
      repeat (5) step();

      // Round robin: tie goes to wash, then alternation.
      do_reset();
      wash_sel = 4'b0001; shop_sel = 4'b0010;
      req_wash = 1'b1; req_shop = 1'b1;                      // c
      step(); req_wash = 1'b0; req_shop = 1'b0;              // c+1
      step(); @(negedge clk);                                // c+2
      pin("rr first grant_wash", 32'(grant_wash), 1);
      pin("rr first prog", 32'(prog), 1);
      repeat (6) step(); @(negedge clk);                     // c+8
      pin("rr second grant_shop", 32'(grant_shop), 1);
      pin("rr second prog", 32'(prog), 2);
      for (int i = 0; i < 4; i++) begin
         step();
         if (i % 2 == 0) req_wash = 1'b1; else req_shop = 1'b1;
         step();
         req_wash = 1'b0; req_shop = 1'b0;
      end
      repeat (60) step();

      // Queue full on wash while shop is served.
      do_reset();
      shop_sel = 4'b1000; wash_sel = 4'b0001;
      req_shop = 1'b1; step(); req_shop = 1'b0; step();      // c+2, serving
      for (int i = 0; i < 8; i++) begin
         req_wash = 1'b1;
         if (i == 7) begin
            @(negedge clk);
            pin("full reject on 8th", 32'(reject_wash), 1);
            pin("full q_wash sat", 32'(q_wash), 7);
         end
         step(); req_wash = 1'b0; step();
      end
      wait_done(40);                                         // shop done
      step();                                                // idle: wash 7->6
      wait_done(40);                                         // first wash done
      step(); req_wash = 1'b1;                               // idle: dec + pulse
      @(negedge clk);
      pin("full dec+pulse reject", 32'(reject_wash), 0);
      step(); req_wash = 1'b0;
      @(negedge clk);
      pin("full dec+pulse q_wash", 32'(q_wash), 6);
      step();

      // Selector decode and mid-service selector change.
      do_reset();
      wash_sel = 4'b0000; req_wash = 1'b1;
      step(); req_wash = 1'b0;
      step(); @(negedge clk);
      pin("sel 0000 prog", 32'(prog), 1);
      wait_done(40);
      step();
      wash_sel = 4'b0110; req_wash = 1'b1;
      step(); req_wash = 1'b0;
      step(); @(negedge clk);
      pin("sel 0110 prog", 32'(prog), 2);
      step(); wash_sel = 4'b0001;
      step(); step(); @(negedge clk);
      pin("sel change prog held", 32'(prog), 2);
      pin("sel change grant held", 32'(grant_wash), 1);
      wait_done(40);
      repeat (3) step();

      // Abort on 3rd cycle of a shop service with a wash car waiting.
      do_reset();
      shop_sel = 4'b1000; wash_sel = 4'b0010;
      req_shop = 1'b1;                                       // c
      step(); req_shop = 1'b0;                               // c+1
      step(); req_wash = 1'b1;                               // c+2
      step(); req_wash = 1'b0;                               // c+3
      step(); abort = 1'b1;                                  // c+4
      step(); abort = 1'b0;                                  // c+5
      @(negedge clk);
      pin("abort grant_shop", 32'(grant_shop), 0);
      pin("abort done", 32'(done), 0);
      pin("abort q_wash", 32'(q_wash), 1);
      step(); @(negedge clk);                                // c+6
      pin("abort next grant_wash", 32'(grant_wash), 1);
      wait_done(40);
      step(); abort = 1'b1;
      repeat (10) step();
      abort = 1'b0;

      // Reset during service with three shop cars queued.
      do_reset();
      shop_sel = 4'b1000;
      req_shop = 1'b1; step(); req_shop = 1'b0; step();      // c+2
      for (int i = 0; i < 3; i++) begin
         step(); req_shop = 1'b1; step(); req_shop = 1'b0;
      end                                                    // c+8
      @(negedge clk);
      pin("midrst q_shop", 32'(q_shop), 3);
      pin("midrst busy", 32'(busy), 1);
      step(); reset = 1'b1;                                  // c+9
      step(); reset = 1'b0; req_wash = 1'b1; req_shop = 1'b1; // c+10
      @(negedge clk);
      pin("midrst grant_shop", 32'(grant_shop), 0);
      pin("midrst done", 32'(done), 0);
      pin("midrst q_shop 0", 32'(q_shop), 0);
      step(); req_wash = 1'b0; req_shop = 1'b0;
      step(); @(negedge clk);
      pin("midrst tie grant_wash", 32'(grant_wash), 1);
      repeat (40) step();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         req_wash = ($urandom_range(0, 2) == 0);
         req_shop = ($urandom_range(0, 2) == 0);
         wash_sel = 4'($urandom_range(0, 15));
         shop_sel = 4'($urandom_range(0, 15));
         abort    = ($urandom_range(0, 39) == 0);
         reset    = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0; req_wash = 1'b0; req_shop = 1'b0; abort = 1'b0;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
